// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per handshake, fixed-latency response,
// word-organised backing array with byte-lane writes.
module dmem_responder #(
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned Depth   = 1 << AW;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wdata_q, wdata_d;

  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] idx;
  logic          resp, accept, mis;

  // Upper address bits alias; only the in-range part is captured.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign idx = addr_q[AW+1:2];

  always_comb begin
    resp    = (state_q == StBusy) && (cnt_q == 4'd0);
    addr_ok = (state_q == StIdle) || resp;
    accept  = req && addr_ok;
    mis     = ((size_q == 2'd1) && addr_q[0]) ||
              ((size_q == 2'd2) && (addr_q[1:0] != 2'b00)) ||
              (size_q == 2'd3);
    data_ok = resp;
    err     = resp && mis;
    rdata   = (resp && !wr_q && !mis) ? mem_q[idx] : 32'd0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    if (accept) begin
      state_d = StBusy;
      cnt_d   = CntLoad;
      wr_d    = wr;
      size_d  = size;
      addr_d  = addr[AW+1:0];
      sel_d   = sel;
      wdata_d = wdata;
    end else if ((state_q == StBusy) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else if (resp) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  // Array is never cleared; a reset on the response edge drops the store.
  always_ff @(posedge clk) begin
    if (rst && resp && wr_q && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
